// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - binary32 field view, constants and state encoding for the argmax stage
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } argmax_state_t;

    function automatic logic is_nan(input fp32_t v);
        return (v.exp == FP_EXP_MAX) && (v.mant != 23'd0);
    endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// rtl/fp_cmp_core.sv - combinational binary32 compare producing gt, eq and unordered
module fp_cmp_core
    import fp_pkg::*;
(
    input  fp32_t i_a,
    input  fp32_t i_b,
    output logic  o_gt,
    output logic  o_eq,
    output logic  o_unordered
);

    logic        w_a_zero;
    logic        w_b_zero;
    logic [30:0] w_a_mag;
    logic [30:0] w_b_mag;
    logic        w_gt_raw;
    logic        w_eq_raw;

    assign w_a_mag     = {i_a.exp, i_a.mant};
    assign w_b_mag     = {i_b.exp, i_b.mant};
    assign w_a_zero    = (w_a_mag == 31'd0);
    assign w_b_zero    = (w_b_mag == 31'd0);
    assign o_unordered = is_nan(i_a) || is_nan(i_b);

    // Sign-magnitude ordering; +0 and -0 are equal, denormals order by bit pattern
    always_comb begin
        w_eq_raw = (i_a == i_b) || (w_a_zero && w_b_zero);
        w_gt_raw = 1'b0;
        if (w_a_zero && w_b_zero) begin
            w_gt_raw = 1'b0;
        end else if (i_a.sign != i_b.sign) begin
            w_gt_raw = !i_a.sign;
        end else if (!i_a.sign) begin
            w_gt_raw = (w_a_mag > w_b_mag);
        end else begin
            w_gt_raw = (w_a_mag < w_b_mag);
        end
    end

    assign o_gt = w_gt_raw && !o_unordered;
    assign o_eq = w_eq_raw && !o_unordered;

endmodule

// File: rtl/fp_stream_argmax.sv
// rtl/fp_stream_argmax.sv - per-packet running max and position of a binary32 stream (option: FP_ARGMAX_NAN_PROPAGATE_EN)
module fp_stream_argmax
    import fp_pkg::*;
#(
    parameter int IDX_W          = 16,
    parameter int TIE_KEEP_FIRST = 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_max,
    output logic [IDX_W-1:0] m_index,
    output logic [IDX_W-1:0] m_count,
    output logic             m_overflow
);

    localparam logic TIE_REPLACES = (TIE_KEEP_FIRST == 0);

    argmax_state_t    r_state;
    logic             r_s_ready;
    logic             r_m_valid;
    logic [31:0]      r_max;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_pos;
    logic             r_ovf;

    fp32_t            w_data;
    logic             w_s_fire;
    logic             w_d_nan;
    logic [IDX_W-1:0] w_pos_next;
    logic             w_gt;
    logic             w_eq;
    logic             w_unord;
    logic             w_ordered_win;
    logic             w_replace;
    logic [31:0]      w_load_val;

    assign w_data        = fp32_t'(s_data);
    assign w_s_fire      = s_valid && r_s_ready;
    assign w_d_nan       = is_nan(w_data);
    assign w_pos_next    = r_pos + {{(IDX_W-1){1'b0}}, 1'b1};
    assign w_ordered_win = !w_unord && (w_gt || (TIE_REPLACES && w_eq));

    fp_cmp_core u_cmp (
        .i_a         (w_data),
        .i_b         (fp32_t'(r_max)),
        .o_gt        (w_gt),
        .o_eq        (w_eq),
        .o_unordered (w_unord)
    );

`ifdef FP_ARGMAX_NAN_PROPAGATE_EN
    logic r_nan_lat;

    // Once a NaN has been seen the packet result is pinned to the canonical quiet NaN
    assign w_replace  = !r_nan_lat && (w_d_nan || w_ordered_win);
    assign w_load_val = w_d_nan ? FP_QNAN : s_data;

    // Remember that the current packet already latched a NaN
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_nan_lat <= 1'b0;
        end else if (w_s_fire) begin
            if (r_state == ST_FIRST) begin
                r_nan_lat <= w_d_nan;
            end else if (w_d_nan) begin
                r_nan_lat <= 1'b1;
            end
        end
    end
`else
    logic w_max_nan;

    // A NaN can only sit in the max slot when it was the first element; any ordered value displaces it
    assign w_max_nan  = is_nan(fp32_t'(r_max));
    assign w_replace  = w_max_nan ? !w_d_nan : w_ordered_win;
    assign w_load_val = s_data;
`endif

    // Packet FSM: load first element, accumulate, then hold the result until taken
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= ST_FIRST;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_max     <= 32'd0;
            r_idx     <= '0;
            r_pos     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_FIRST: begin
                    r_s_ready <= 1'b1;
                    if (w_s_fire) begin
                        r_max <= w_load_val;
                        r_idx <= '0;
                        r_pos <= '0;
                        r_ovf <= 1'b0;
                        if (s_last) begin
                            r_state   <= ST_DONE;
                            r_s_ready <= 1'b0;
                            r_m_valid <= 1'b1;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    r_s_ready <= 1'b1;
                    if (w_s_fire) begin
                        r_pos <= w_pos_next;
                        if (w_pos_next == '0) begin
                            r_ovf <= 1'b1;
                        end
                        if (w_replace) begin
                            r_max <= w_load_val;
                            r_idx <= w_pos_next;
                        end
                        if (s_last) begin
                            r_state   <= ST_DONE;
                            r_s_ready <= 1'b0;
                            r_m_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        r_state   <= ST_FIRST;
                        r_s_ready <= 1'b1;
                        r_m_valid <= 1'b0;
                        r_ovf     <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_FIRST;
                    r_s_ready <= 1'b0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign m_valid    = r_m_valid;
    assign m_max      = r_max;
    assign m_index    = r_idx;
    assign m_count    = r_pos;
    assign m_overflow = r_ovf;

endmodule

// File: tb/tb_fp_stream_argmax.sv
// tb/tb_fp_stream_argmax.sv - directed bench for fp_stream_argmax, keep-first/16-bit and replace/2-bit instances
module tb_fp_stream_argmax;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        a_s_ready, a_m_valid, a_m_overflow;
    logic [31:0] a_m_max;
    logic [15:0] a_m_index, a_m_count;

    logic        b_s_ready, b_m_valid, b_m_overflow;
    logic [31:0] b_m_max;
    logic [1:0]  b_m_index, b_m_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 aclk = ~aclk;

    fp_stream_argmax #(.IDX_W(16), .TIE_KEEP_FIRST(1)) u_dut_a (
        .aclk(aclk), .areset(areset),
        .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_max(a_m_max),
        .m_index(a_m_index), .m_count(a_m_count), .m_overflow(a_m_overflow)
    );

    fp_stream_argmax #(.IDX_W(2), .TIE_KEEP_FIRST(0)) u_dut_b (
        .aclk(aclk), .areset(areset),
        .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_max(b_m_max),
        .m_index(b_m_index), .m_count(b_m_count), .m_overflow(b_m_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!a_s_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic take();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic check_result(input string tag,
                                input logic [31:0] amax, input int aidx, input int acnt, input logic aovf,
                                input logic [31:0] bmax, input int bidx, input int bcnt, input logic bovf);
        chk({tag, "_a_valid"}, 32'(a_m_valid), 32'd1);
        chk({tag, "_a_max"},   a_m_max, amax);
        chk({tag, "_a_idx"},   32'(a_m_index), 32'(aidx));
        chk({tag, "_a_cnt"},   32'(a_m_count), 32'(acnt));
        chk({tag, "_a_ovf"},   32'(a_m_overflow), 32'(aovf));
        chk({tag, "_a_sready"}, 32'(a_s_ready), 32'd0);
        chk({tag, "_b_valid"}, 32'(b_m_valid), 32'd1);
        chk({tag, "_b_max"},   b_m_max, bmax);
        chk({tag, "_b_idx"},   32'(b_m_index), 32'(bidx));
        chk({tag, "_b_cnt"},   32'(b_m_count), 32'(bcnt));
        chk({tag, "_b_ovf"},   32'(b_m_overflow), 32'(bovf));
        take();
        chk({tag, "_a_drop"},  32'(a_m_valid), 32'd0);
        chk({tag, "_a_ready"}, 32'(a_s_ready), 32'd1);
        chk({tag, "_b_ovfclr"}, 32'(b_m_overflow), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_sready", 32'(a_s_ready), 32'd0);
        chk("rst_valid",  32'(a_m_valid), 32'd0);
        chk("rst_max",    a_m_max, 32'd0);
        chk("rst_idx",    32'(a_m_index), 32'd0);
        chk("rst_cnt",    32'(a_m_count), 32'd0);
        chk("rst_ovf",    32'(a_m_overflow), 32'd0);
        areset = 1'b0;
        tick();
        chk("rst_sready_up", 32'(a_s_ready), 32'd1);

        // basic packet, result visible right after the last element's edge
        send(32'h3FC00000, 1'b0);
        send(32'h40200000, 1'b0);
        send(32'hBF800000, 1'b1);
        check_result("basic", 32'h40200000, 1, 2, 1'b0, 32'h40200000, 1, 2, 1'b0);

        // equal values: keep-first instance vs replace instance
        send(32'h3FC00000, 1'b0);
        send(32'h3FC00000, 1'b1);
        check_result("tie", 32'h3FC00000, 0, 1, 1'b0, 32'h3FC00000, 1, 1, 1'b0);

        send(32'h00000000, 1'b0);
        send(32'h80000000, 1'b1);
        check_result("zero", 32'h00000000, 0, 1, 1'b0, 32'h80000000, 1, 1, 1'b0);

        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b1);
        check_result("denorm", 32'h00000002, 1, 1, 1'b0, 32'h00000002, 1, 1, 1'b0);

        send(32'hBF800000, 1'b0);
        send(32'h7FC00000, 1'b0);
        send(32'hC0000000, 1'b1);
`ifdef FP_ARGMAX_NAN_PROPAGATE_EN
        check_result("nan_mid", 32'h7FC00000, 1, 2, 1'b0, 32'h7FC00000, 1, 2, 1'b0);
`else
        check_result("nan_mid", 32'hBF800000, 0, 2, 1'b0, 32'hBF800000, 0, 2, 1'b0);
`endif

        send(32'h7FC00000, 1'b0);
        send(32'hC0000000, 1'b0);
        send(32'hBF800000, 1'b1);
`ifdef FP_ARGMAX_NAN_PROPAGATE_EN
        check_result("nan_first", 32'h7FC00000, 0, 2, 1'b0, 32'h7FC00000, 0, 2, 1'b0);
`else
        check_result("nan_first", 32'hBF800000, 2, 2, 1'b0, 32'hBF800000, 2, 2, 1'b0);
`endif

        // backpressure: result held, next element waits
        send(32'h40400000, 1'b1);
        s_valid = 1'b1;
        s_data  = 32'h41000000;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",  32'(a_m_valid), 32'd1);
            chk("stall_max",    a_m_max, 32'h40400000);
            chk("stall_sready", 32'(a_s_ready), 32'd0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("stall_release_valid",  32'(a_m_valid), 32'd0);
        chk("stall_release_sready", 32'(a_s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("stall_next_valid", 32'(a_m_valid), 32'd1);
        chk("stall_next_max",   a_m_max, 32'h41000000);
        chk("stall_next_cnt",   32'(a_m_count), 32'd0);
        take();

        // reset in the middle of a packet
        send(32'h40A00000, 1'b0);
        send(32'h40C00000, 1'b0);
        areset = 1'b1;
        tick();
        chk("midrst_sready", 32'(a_s_ready), 32'd0);
        chk("midrst_valid",  32'(a_m_valid), 32'd0);
        chk("midrst_max",    a_m_max, 32'd0);
        chk("midrst_idx",    32'(a_m_index), 32'd0);
        chk("midrst_cnt",    32'(a_m_count), 32'd0);
        chk("midrst_b_max",  b_m_max, 32'd0);
        areset = 1'b0;
        tick();
        send(32'h40200000, 1'b1);
        check_result("after_rst", 32'h40200000, 0, 0, 1'b0, 32'h40200000, 0, 0, 1'b0);

        // five ascending elements: the 2-bit instance wraps
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'h40800000, 1'b0);
        send(32'h40A00000, 1'b1);
        check_result("wrap", 32'h40A00000, 4, 4, 1'b0, 32'h40A00000, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
